loop_mem_seq: RTL
=================

LOOP_MEM_SEQ -- requirements
Module: loop_mem_seq

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clk100 in 1, 100 MHz system clock; rst in 1, asynchronous active-high reset.
REQ-002 SHALL expose these ports:
- sample_tick in 1: one-cycle strobe per audio sample.
- audio_in in 16: signed live sample, valid on sample_tick.
- playing in 8: per-bank play enables.
- recording in 8: per-bank record enables.
- delete in 1: level request to clear a bank.
- delete_bank in 3: bank to clear.
- set_max in 1: latch the loop length.
- reset_max in 1: clear the loop length.
- current_max out 23: loop length in samples, 0 means unset.
- delete_clear out 1: one-cycle pulse when a clear completes.
- mem_req out 1: memory request.
- mem_we out 1: 1 for write, 0 for read.
- mem_addr out 26: address {bank[2:0], offset[22:0]}.
- mem_wdata out 16: write data.
- mem_ack in 1: one-cycle completion; mem_rdata is valid with it on reads.
- mem_rdata in 16: read data.
- mix_out out 16: signed mixed output sample.
- mix_valid out 1: one-cycle strobe when mix_out updates.
- tick_overrun out 1: one-cycle pulse when a tick is dropped.
REQ-003 SHALL define parameters NUM_BANKS=8, OFFSET_W=23 and SAMPLE_W=16.

Function
REQ-004 SHALL hold position pos[22:0].
- On each accepted tick, service uses svc_pos = pos captured at the tick.
- pos advances when service finishes.
- If current_max==0: pos increments and saturates at 2^23-1.
- Otherwise pos wraps from current_max-1 to 0.
REQ-005 set_max=1 SHALL set current_max <= pos+1 (saturating at 2^23-1) and pos <= 0 in the same cycle.
REQ-006 reset_max=1 SHALL set current_max <= 0 and pos <= 0. It has priority over set_max.
REQ-007 If set_max or reset_max occurs during service, the service in flight SHALL keep svc_pos. The pending advance is discarded, and pos stays at 0.
REQ-008 Service SHALL scan banks 0..7 in ascending order:
- recording[b]=1: write audio_in to {b, svc_pos}.
- recording[b]=0 and playing[b]=1: read {b, svc_pos} and add it to a signed 19-bit accumulator.
- Both 0: skip the bank in 1 cycle.
- Record takes precedence; a bank with both bits set is written only.
REQ-009 The accumulator SHALL start at sign-extended audio_in (live monitor). At the end it is saturated to [-32768, 32767], driven on mix_out, and mix_valid pulses for 1 cycle.
REQ-010 Handshake rules:
- mem_req is held until mem_ack.
- mem_addr, mem_we and mem_wdata are stable while mem_req=1.
- mem_req drops the cycle after mem_ack.
- Only one transaction is outstanding at a time.
REQ-011 A rising edge of delete SHALL start a clear sweep:
- delete_bank is captured on that edge.
- The sweep writes 0 to offsets 0..2^23-1 of that bank.
- delete_clear pulses 1 cycle after the last ack.
REQ-012 Sample service SHALL have priority over the clear sweep.
- The sweep pauses between transactions while a service is pending and resumes at the next offset.
- A delete edge during an active sweep is ignored.
REQ-013 A sample_tick arriving while service is active SHALL be dropped and SHALL pulse tick_overrun. pos does not advance for a dropped tick.
REQ-014 FSM states and transitions:
- IDLE -> SCAN on a tick.
- SCAN -> WR_REQ, RD_REQ or next bank.
- WR_REQ/RD_REQ -> WAIT_ACK.
- WAIT_ACK -> SCAN on ack.
- SCAN past bank 7 -> MIX_OUT -> IDLE.
- IDLE -> CLR_WR when a sweep is pending and no tick.
- CLR_WR -> CLR_WAIT -> IDLE.

Reset
REQ-015 rst SHALL asynchronously clear outputs and state:
- Outputs: current_max, delete_clear, mem_req, mem_we, mem_addr, mem_wdata, mix_out, mix_valid and tick_overrun reset to 0.
- Internal: pos=0, FSM=IDLE, sweep inactive, delete edge register=0.
REQ-016 Reset mid-transaction SHALL abandon the transaction: mem_req falls immediately and no delete_clear is issued.

Structure
REQ-017 Package loop_pkg SHALL hold NUM_BANKS, OFFSET_W, SAMPLE_W, ACC_W=19 and the FSM state type.
REQ-018 The position/length logic (REQ-004..007) SHALL be the sub-module loop_pos_ctr.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- recording=8'h01, audio_in=16'h1234, tick with pos=5 -> one write to addr {0,5} with data 1234; pos=6; mix_out=1234.
- recording=0, playing=8'h06, reads return 16'h7000 and 16'h7000, audio_in=16'h1000, tick -> reads at banks 1 then 2; mix_out=16'h7FFF (saturated); mix_valid pulses once.
- pos=99, set_max pulse -> current_max=100, pos=0. After 100 ticks pos=0 (wrap at 99). reset_max -> current_max=0.
- delete edge, delete_bank=3, with ticks every 2083 cycles -> every tick is serviced and no tick_overrun. Clear writes cover {3,0}..{3,7FFFFF}. delete_clear pulses once.
- Second tick while WAIT_ACK is stalled by withholding ack -> tick_overrun pulses and pos advances only once.
- rst asserted while mem_req=1 during a sweep -> mem_req=0 in the same cycle, all outputs 0, and no delete_clear after reset.

Source files
------------

// File: rtl/loop_pkg.sv
// Shared widths and FSM state encoding for the loop-sampler memory sequencer.
package loop_pkg;
  localparam int NUM_BANKS = 8;
  localparam int OFFSET_W  = 23;
  localparam int SAMPLE_W  = 16;
  localparam int ACC_W     = 19;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_SCAN     = 3'd1;
  localparam state_t ST_WR_REQ   = 3'd2;
  localparam state_t ST_RD_REQ   = 3'd3;
  localparam state_t ST_WAIT_ACK = 3'd4;
  localparam state_t ST_MIX_OUT  = 3'd5;
  localparam state_t ST_CLR_WR   = 3'd6;
  localparam state_t ST_CLR_WAIT = 3'd7;
endpackage

// File: rtl/loop_pos_ctr.sv
// Loop position and loop length: pos advances once per completed service,
// wrapping at current_max when a length is latched, saturating otherwise.
module loop_pos_ctr #(
  parameter int OFFSET_W = loop_pkg::OFFSET_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                svc_start,
  input  logic                svc_done,
  input  logic                set_max,
  input  logic                reset_max,
  output logic [OFFSET_W-1:0] pos,
  output logic [OFFSET_W-1:0] current_max
);
  localparam logic [OFFSET_W-1:0] POS_MAX = '1;

  // Cleared by set/reset_max so a service in flight does not move pos off 0.
  logic armed_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos         <= '0;
      current_max <= '0;
      armed_reg   <= 1'b0;
    end else if (reset_max) begin
      pos         <= '0;
      current_max <= '0;
      armed_reg   <= 1'b0;
    end else if (set_max) begin
      pos         <= '0;
      current_max <= (pos == POS_MAX) ? POS_MAX : pos + 1'b1;
      armed_reg   <= 1'b0;
    end else begin
      if (svc_start) armed_reg <= 1'b1;
      else if (svc_done) armed_reg <= 1'b0;
      if (svc_done && armed_reg) begin
        if (current_max == '0) pos <= (pos == POS_MAX) ? POS_MAX : pos + 1'b1;
        else if (pos >= current_max - 1'b1) pos <= '0;
        else pos <= pos + 1'b1;
      end
    end
  end
endmodule

// File: rtl/loop_mem_seq.sv
// Per-sample bank record/playback sequencer with a background bank-clear sweep,
// sharing one request/ack memory port; sample service always wins over the sweep.
module loop_mem_seq #(
  parameter int  NUM_BANKS = loop_pkg::NUM_BANKS,
  parameter int  OFFSET_W  = loop_pkg::OFFSET_W,
  parameter int  SAMPLE_W  = loop_pkg::SAMPLE_W,
  localparam int BANK_W    = $clog2(NUM_BANKS),
  localparam int ADDR_W    = BANK_W + OFFSET_W
) (
  input  logic                 clk100,
  input  logic                 rst,
  input  logic                 sample_tick,
  input  logic [SAMPLE_W-1:0]  audio_in,
  input  logic [NUM_BANKS-1:0] playing,
  input  logic [NUM_BANKS-1:0] recording,
  input  logic                 delete,
  input  logic [BANK_W-1:0]    delete_bank,
  input  logic                 set_max,
  input  logic                 reset_max,
  output logic [OFFSET_W-1:0]  current_max,
  output logic                 delete_clear,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [SAMPLE_W-1:0]  mem_wdata,
  input  logic                 mem_ack,
  input  logic [SAMPLE_W-1:0]  mem_rdata,
  output logic [SAMPLE_W-1:0]  mix_out,
  output logic                 mix_valid,
  output logic                 tick_overrun
);
  import loop_pkg::*;

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** (SAMPLE_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  function automatic logic signed [ACC_W-1:0] widen(input logic [SAMPLE_W-1:0] s);
    return $signed({{(ACC_W - SAMPLE_W){s[SAMPLE_W-1]}}, s});
  endfunction

  function automatic logic [SAMPLE_W-1:0] saturate(input logic signed [ACC_W-1:0] a);
    if (a > SAT_HI) return SAT_HI[SAMPLE_W-1:0];
    if (a < SAT_LO) return SAT_LO[SAMPLE_W-1:0];
    return a[SAMPLE_W-1:0];
  endfunction

  state_t                  state_reg;
  logic [BANK_W:0]         bank_reg;
  logic [OFFSET_W-1:0]     pos;
  logic [OFFSET_W-1:0]     svc_pos_reg;
  logic [OFFSET_W-1:0]     clr_off_reg;
  logic [BANK_W-1:0]       clr_bank_reg;
  logic [NUM_BANKS-1:0]    rec_reg;
  logic [NUM_BANKS-1:0]    play_reg;
  logic [SAMPLE_W-1:0]     audio_reg;
  logic signed [ACC_W-1:0] acc_reg;
  logic                    tick_pend_reg;
  logic                    sweep_reg;
  logic                    delete_d_reg;
  logic                    svc_busy;
  logic                    tick_accept;
  logic                    delete_rise;
  logic                    svc_done;
  logic [BANK_W-1:0]       bank_sel;

  // A tick landing mid-clear is held pending and serviced once that write finishes.
  assign svc_busy    = (state_reg == ST_SCAN) || (state_reg == ST_WR_REQ) ||
                       (state_reg == ST_RD_REQ) || (state_reg == ST_WAIT_ACK) ||
                       (state_reg == ST_MIX_OUT);
  assign tick_accept = sample_tick && !svc_busy && !tick_pend_reg;
  assign delete_rise = delete && !delete_d_reg;
  assign svc_done    = (state_reg == ST_MIX_OUT);
  assign bank_sel    = bank_reg[BANK_W-1:0];

  loop_pos_ctr #(.OFFSET_W(OFFSET_W)) u_pos (
    .clk         (clk100),
    .rst         (rst),
    .svc_start   (tick_accept),
    .svc_done    (svc_done),
    .set_max     (set_max),
    .reset_max   (reset_max),
    .pos         (pos),
    .current_max (current_max)
  );

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      bank_reg      <= '0;
      svc_pos_reg   <= '0;
      clr_off_reg   <= '0;
      clr_bank_reg  <= '0;
      rec_reg       <= '0;
      play_reg      <= '0;
      audio_reg     <= '0;
      acc_reg       <= '0;
      tick_pend_reg <= 1'b0;
      sweep_reg     <= 1'b0;
      delete_d_reg  <= 1'b0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mix_out       <= '0;
      mix_valid     <= 1'b0;
      delete_clear  <= 1'b0;
      tick_overrun  <= 1'b0;
    end else begin
      mix_valid    <= 1'b0;
      delete_clear <= 1'b0;
      tick_overrun <= sample_tick && !tick_accept;
      delete_d_reg <= delete;

      if (delete_rise && !sweep_reg) begin
        sweep_reg    <= 1'b1;
        clr_bank_reg <= delete_bank;
        clr_off_reg  <= '0;
      end

      if (tick_accept) begin
        tick_pend_reg <= 1'b1;
        svc_pos_reg   <= pos;
        rec_reg       <= recording;
        play_reg      <= playing;
        audio_reg     <= audio_in;
        acc_reg       <= widen(audio_in);
      end

      case (state_reg)
        ST_IDLE: begin
          if (tick_pend_reg || tick_accept) begin
            state_reg     <= ST_SCAN;
            bank_reg      <= '0;
            tick_pend_reg <= 1'b0;
          end else if (sweep_reg) begin
            state_reg <= ST_CLR_WR;
          end
        end
        ST_SCAN: begin
          if (bank_reg == (BANK_W + 1)'(NUM_BANKS)) state_reg <= ST_MIX_OUT;
          else if (rec_reg[bank_sel]) state_reg <= ST_WR_REQ;
          else if (play_reg[bank_sel]) state_reg <= ST_RD_REQ;
          else bank_reg <= bank_reg + 1'b1;
        end
        ST_WR_REQ: begin
          mem_req   <= 1'b1;
          mem_we    <= 1'b1;
          mem_addr  <= {bank_sel, svc_pos_reg};
          mem_wdata <= audio_reg;
          state_reg <= ST_WAIT_ACK;
        end
        ST_RD_REQ: begin
          mem_req   <= 1'b1;
          mem_we    <= 1'b0;
          mem_addr  <= {bank_sel, svc_pos_reg};
          state_reg <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) acc_reg <= acc_reg + widen(mem_rdata);
            bank_reg  <= bank_reg + 1'b1;
            state_reg <= ST_SCAN;
          end
        end
        ST_MIX_OUT: begin
          mix_out   <= saturate(acc_reg);
          mix_valid <= 1'b1;
          state_reg <= ST_IDLE;
        end
        ST_CLR_WR: begin
          mem_req   <= 1'b1;
          mem_we    <= 1'b1;
          mem_addr  <= {clr_bank_reg, clr_off_reg};
          mem_wdata <= '0;
          state_reg <= ST_CLR_WAIT;
        end
        ST_CLR_WAIT: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            state_reg <= ST_IDLE;
            if (clr_off_reg == '1) begin
              sweep_reg    <= 1'b0;
              delete_clear <= 1'b1;
            end else begin
              clr_off_reg <= clr_off_reg + 1'b1;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end
endmodule
